// File: rtl/axi4lite_uart_regbank.sv
// AXI4-Lite register bank bridging the slave front-end to the UART TX/RX streams:
// TX FIFO, RX holding register, sticky STATUS, CTRL with level IRQ, scratch regs.
module axi4lite_uart_regbank #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TX_DEPTH    = 4,
  parameter int unsigned NUM_SCRATCH = 2,
  parameter bit          RX_BLOCKING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_amba,
  input  logic                  rd_amba,
  input  logic [31:0]           addr_wc,
  input  logic [31:0]           addr_rc,
  input  logic [DATA_W/8-1:0]   strb,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  txValid,
  input  logic                  txReady,
  output logic                  irq
);

  localparam int unsigned AW = $clog2(4 + NUM_SCRATCH);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NB = DATA_W / 8;

  localparam logic [AW-1:0] IDX_TX     = AW'(0);
  localparam logic [AW-1:0] IDX_RX     = AW'(1);
  localparam logic [AW-1:0] IDX_STATUS = AW'(2);
  localparam logic [AW-1:0] IDX_CTRL   = AW'(3);

  logic [AW-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0] byte_mask;

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] tx_mem_d [TX_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     tx_count_q, tx_count_d;
  logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_drop_q, tx_drop_d;
  logic              irq_q, irq_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] scratch_q [NUM_SCRATCH];
  logic [DATA_W-1:0] scratch_d [NUM_SCRATCH];

  logic tx_empty, tx_full, tx_pop, tx_push, tx_accept, tx_drop_ev;
  logic status_wr, rx_pop, rx_load, rx_ovr_ev;
  logic [DATA_W-1:0] status_w;

  logic unused_addr;
  assign unused_addr = ^{addr_wc[31:AW+2], addr_wc[1:0], addr_rc[31:AW+2], addr_rc[1:0]};

  assign wr_idx = addr_wc[AW+1:2];
  assign rd_idx = addr_rc[AW+1:2];

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == CW'(TX_DEPTH));
  assign txValid  = !tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem_q[rd_ptr_q];
  assign rxReady  = RX_BLOCKING ? !rx_full_q : 1'b1;
  assign irq      = irq_q;

  // Expand byte strobes into a bit mask and derive per-cycle events.
  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      byte_mask[8*b +: 8] = {8{strb[b]}};
    end
    tx_pop     = !tx_empty && txReady;
    tx_push    = wr_amba && (wr_idx == IDX_TX) && (|strb);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    tx_accept  = tx_push && (!tx_full || tx_pop);
    tx_drop_ev = tx_push && !tx_accept;
    status_wr  = wr_amba && (wr_idx == IDX_STATUS) && strb[0];
    rx_pop     = rd_amba && (rd_idx == IDX_RX) && rx_full_q;
    rx_load    = rxValid && rxReady;
    rx_ovr_ev  = !RX_BLOCKING && rxValid && rx_full_q && !rx_pop;
  end

  // Next-state for FIFO, RX holding, sticky flags, CTRL, scratch and IRQ.
  always_comb begin
    tx_mem_d   = tx_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_count_d = tx_count_q;
    if (tx_accept) begin
      tx_mem_d[wr_ptr_q] = data_in & byte_mask;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (tx_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (tx_accept && !tx_pop)      tx_count_d = tx_count_q + CW'(1);
    else if (tx_pop && !tx_accept) tx_count_d = tx_count_q - CW'(1);

    rx_hold_d = rx_load ? rx_data : rx_hold_q;
    if (rx_load)     rx_full_d = 1'b1;
    else if (rx_pop) rx_full_d = 1'b0;
    else             rx_full_d = rx_full_q;

    // New error events take priority over a W1C clear in the same cycle.
    if (rx_ovr_ev)                     rx_overrun_d = 1'b1;
    else if (status_wr && data_in[3])  rx_overrun_d = 1'b0;
    else                               rx_overrun_d = rx_overrun_q;
    if (tx_drop_ev)                    tx_drop_d = 1'b1;
    else if (status_wr && data_in[4])  tx_drop_d = 1'b0;
    else                               tx_drop_d = tx_drop_q;

    ctrl_d = ctrl_q;
    if (wr_amba && (wr_idx == IDX_CTRL) && strb[0]) ctrl_d = data_in[2:0];

    scratch_d = scratch_q;
    for (int unsigned k = 0; k < NUM_SCRATCH; k++) begin
      if (wr_amba && (wr_idx == AW'(4 + k))) begin
        scratch_d[k] = (scratch_q[k] & ~byte_mask) | (data_in & byte_mask);
      end
    end

    irq_d = (ctrl_q[0] & rx_full_q) | (ctrl_q[1] & tx_empty) |
            (ctrl_q[2] & (rx_overrun_q | tx_drop_q));
  end

  // Read data mux, combinational on the read address.
  always_comb begin
    status_w          = '0;
    status_w[0]       = rx_full_q;
    status_w[1]       = tx_full;
    status_w[2]       = tx_empty;
    status_w[3]       = rx_overrun_q;
    status_w[4]       = tx_drop_q;
    status_w[8 +: CW] = tx_count_q;
    data_out = '0;
    case (rd_idx)
      IDX_RX:     data_out = rx_hold_q;
      IDX_STATUS: data_out = status_w;
      IDX_CTRL:   data_out = {{(DATA_W-3){1'b0}}, ctrl_q};
      default: begin
        for (int unsigned k = 0; k < NUM_SCRATCH; k++) begin
          if (rd_idx == AW'(4 + k)) data_out = scratch_q[k];
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tx_count_q   <= '0;
      rx_hold_q    <= '0;
      rx_full_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      irq_q        <= 1'b0;
      ctrl_q       <= '0;
      for (int unsigned k = 0; k < NUM_SCRATCH; k++) scratch_q[k] <= '0;
    end else begin
      tx_mem_q     <= tx_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tx_count_q   <= tx_count_d;
      rx_hold_q    <= rx_hold_d;
      rx_full_q    <= rx_full_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
      irq_q        <= irq_d;
      ctrl_q       <= ctrl_d;
      scratch_q    <= scratch_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_uart_regbank.sv
// Bench for axi4lite_uart_regbank: one blocking-RX and one overwrite-RX instance
// share all inputs; a queue-based model is compared on every falling edge,
// and directed steps add literal expectations.
module tb_axi4lite_uart_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_amba = 1'b0, rd_amba = 1'b0;
  logic [31:0] addr_wc = '0, addr_rc = '0;
  logic [3:0]  strb = '0;
  logic [31:0] data_in = '0, rx_data = '0;
  logic        rxValid = 1'b0, txReady = 1'b0;

  logic [31:0] dout0, dout1, txd0, txd1;
  logic        rxr0, rxr1, txv0, txv1, irq0, irq1;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi4lite_uart_regbank #(.DATA_W(32), .TX_DEPTH(4), .NUM_SCRATCH(2), .RX_BLOCKING(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_amba(wr_amba), .rd_amba(rd_amba),
    .addr_wc(addr_wc), .addr_rc(addr_rc), .strb(strb), .data_in(data_in),
    .data_out(dout0), .rx_data(rx_data), .rxValid(rxValid), .rxReady(rxr0),
    .tx_data(txd0), .txValid(txv0), .txReady(txReady), .irq(irq0));

  axi4lite_uart_regbank #(.DATA_W(32), .TX_DEPTH(4), .NUM_SCRATCH(2), .RX_BLOCKING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .wr_amba(wr_amba), .rd_amba(rd_amba),
    .addr_wc(addr_wc), .addr_rc(addr_rc), .strb(strb), .data_in(data_in),
    .data_out(dout1), .rx_data(rx_data), .rxValid(rxValid), .rxReady(rxr1),
    .tx_data(txd1), .txValid(txv1), .txReady(txReady), .irq(irq1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = blocking, 1 = overwrite) ----
  bit [31:0] m_q[$];
  bit        m_drop;
  bit [2:0]  m_ctrl;
  bit [31:0] m_scr[2];
  bit [31:0] m_hold[2];
  bit        m_full[2], m_ovr[2], m_irq[2];

  task automatic model_reset();
    m_q.delete();
    m_drop = 1'b0;
    m_ctrl = '0;
    for (int i = 0; i < 2; i++) begin
      m_scr[i] = '0; m_hold[i] = '0; m_full[i] = 1'b0; m_ovr[i] = 1'b0; m_irq[i] = 1'b0;
    end
  endtask

  function automatic bit [31:0] m_status(input int m);
    bit [31:0] s;
    int c;
    c = m_q.size();
    s = '0;
    s[15:8] = 8'(c);
    s[4] = m_drop;
    s[3] = m_ovr[m];
    s[2] = (c == 0);
    s[1] = (c == 4);
    s[0] = m_full[m];
    return s;
  endfunction

  function automatic bit [31:0] m_read(input int m, input bit [31:0] a);
    case ((a >> 2) & 32'h7)
      32'd1:   return m_hold[m];
      32'd2:   return m_status(m);
      32'd3:   return {29'b0, m_ctrl};
      32'd4:   return m_scr[0];
      32'd5:   return m_scr[1];
      default: return 32'h0;
    endcase
  endfunction

  // What the registers become at the coming rising edge, given current inputs.
  task automatic model_step();
    bit [31:0] wi, ri, masked;
    bit        pop, push, accept, stw, rdy, rpop, ld, ovr_ev;
    bit        irq_n[2];
    wi = (addr_wc >> 2) & 32'h7;
    ri = (addr_rc >> 2) & 32'h7;
    for (int m = 0; m < 2; m++)
      irq_n[m] = (m_ctrl[0] && m_full[m]) || (m_ctrl[1] && m_q.size() == 0) ||
                 (m_ctrl[2] && (m_ovr[m] || m_drop));
    masked = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) masked[8*b +: 8] = data_in[8*b +: 8];
    pop    = (m_q.size() != 0) && txReady;
    push   = wr_amba && wi == 0 && strb != 4'b0;
    accept = push && (m_q.size() < 4 || pop);
    stw    = wr_amba && wi == 2 && strb[0];
    if (pop) void'(m_q.pop_front());
    if (accept) m_q.push_back(masked);
    if (push && !accept) m_drop = 1'b1;
    else if (stw && data_in[4]) m_drop = 1'b0;
    if (wr_amba && wi == 3 && strb[0]) m_ctrl = data_in[2:0];
    for (int k = 0; k < 2; k++)
      if (wr_amba && wi == 32'(4 + k)) m_scr[k] = (m_scr[k] & ~masked_mask()) | masked;
    for (int m = 0; m < 2; m++) begin
      rdy    = (m == 0) ? !m_full[m] : 1'b1;
      rpop   = rd_amba && ri == 1 && m_full[m];
      ld     = rxValid && rdy;
      ovr_ev = (m == 1) && rxValid && m_full[m] && !rpop;
      if (ld) m_hold[m] = rx_data;
      if (ld) m_full[m] = 1'b1;
      else if (rpop) m_full[m] = 1'b0;
      if (ovr_ev) m_ovr[m] = 1'b1;
      else if (stw && data_in[3]) m_ovr[m] = 1'b0;
      m_irq[m] = irq_n[m];
    end
  endtask

  function automatic bit [31:0] masked_mask();
    bit [31:0] mk;
    mk = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) mk[8*b +: 8] = 8'hFF;
    return mk;
  endfunction

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("m0_txValid", {31'b0, txv0}, {31'b0, m_q.size() != 0});
    chk("m1_txValid", {31'b0, txv1}, {31'b0, m_q.size() != 0});
    chk("m0_tx_data", txd0, (m_q.size() != 0) ? m_q[0] : 32'h0);
    chk("m1_tx_data", txd1, (m_q.size() != 0) ? m_q[0] : 32'h0);
    chk("m0_rxReady", {31'b0, rxr0}, {31'b0, !m_full[0]});
    chk("m1_rxReady", {31'b0, rxr1}, 32'h1);
    chk("m0_irq", {31'b0, irq0}, {31'b0, m_irq[0]});
    chk("m1_irq", {31'b0, irq1}, {31'b0, m_irq[1]});
    chk("m0_data_out", dout0, m_read(0, addr_rc));
    chk("m1_data_out", dout1, m_read(1, addr_rc));
    if (rst) model_step();
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) -------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_amba = 1'b1; addr_wc = a; data_in = d; strb = s;
    step(1);
    wr_amba = 1'b0; strb = '0;
  endtask

  task automatic rd_at(input logic [31:0] a, output logic [31:0] d0, output logic [31:0] d1);
    addr_rc = a;
    #1;
    d0 = dout0; d1 = dout1;
  endtask

  logic [31:0] r0, r1;
  logic [31:0] exp_seq [4];

  initial begin
    step(3);
    rst = 1'b1;
    chk("rst_txValid", {31'b0, txv0}, 32'h0);
    chk("rst_irq", {31'b0, irq0}, 32'h0);
    chk("rst_tx_data", txd0, 32'h0);
    chk("rst_rxReady_blk", {31'b0, rxr0}, 32'h1);
    chk("rst_rxReady_ovw", {31'b0, rxr1}, 32'h1);
    rd_at(32'h8, r0, r1);
    chk("rst_status", r0, 32'h0000_0004);

    // TX-empty interrupt, then clearing by a push
    wr_reg(32'hC, 32'h2, 4'hF);
    chk("irq_lag", {31'b0, irq0}, 32'h0);
    step(1);
    chk("irq_txempty", {31'b0, irq0}, 32'h1);
    wr_reg(32'h0, 32'h11, 4'hF);
    chk("irq_still", {31'b0, irq0}, 32'h1);
    chk("first_head", txd0, 32'h11);
    step(1);
    chk("irq_cleared", {31'b0, irq0}, 32'h0);

    // Fill the FIFO, then overflow
    wr_reg(32'h0, 32'h22, 4'hF);
    wr_reg(32'h0, 32'h33, 4'hF);
    wr_reg(32'h0, 32'h44, 4'hF);
    rd_at(32'h8, r0, r1);
    chk("status_full", r0, 32'h0000_0402);
    wr_reg(32'h0, 32'h55, 4'hF);
    rd_at(32'h8, r0, r1);
    chk("status_drop", r0, 32'h0000_0412);
    rd_at(32'h0, r0, r1);
    chk("txdata_reads0", r0, 32'h0);

    // Full FIFO: pop and push in the same cycle
    txReady = 1'b1;
    wr_reg(32'h0, 32'h99, 4'hF);
    rd_at(32'h8, r0, r1);
    chk("status_pushpop", r0, 32'h0000_0412);
    exp_seq = '{32'h22, 32'h33, 32'h44, 32'h99};
    for (int i = 0; i < 4; i++) begin
      chk("tx_seq", txd0, exp_seq[i]);
      step(1);
    end
    chk("tx_drained", {31'b0, txv0}, 32'h0);
    txReady = 1'b0;

    // W1C of tx_drop: strb[0]=0 must not clear
    wr_reg(32'h8, 32'h10, 4'b0010);
    rd_at(32'h8, r0, r1);
    chk("w1c_nostrb", r0, 32'h0000_0014);
    wr_reg(32'h8, 32'h10, 4'b0001);
    rd_at(32'h8, r0, r1);
    chk("w1c_drop", r0, 32'h0000_0004);

    // RX path
    rxValid = 1'b1; rx_data = 32'hA5;
    step(1);
    rx_data = 32'h5A;
    chk("rx_blk_notready", {31'b0, rxr0}, 32'h0);
    chk("rx_ovw_ready", {31'b0, rxr1}, 32'h1);
    rd_at(32'h4, r0, r1);
    chk("rx_blk_data", r0, 32'hA5);
    step(1);
    rd_at(32'h4, r0, r1);
    chk("rx_blk_held", r0, 32'hA5);
    chk("rx_ovw_data", r1, 32'h5A);
    rd_at(32'h8, r0, r1);
    chk("rx_blk_status", r0, 32'h0000_0005);
    chk("rx_ovw_status", r1, 32'h0000_000D);
    addr_rc = 32'h4; rd_amba = 1'b1;
    step(1);
    rd_amba = 1'b0;
    chk("rx_blk_ready_again", {31'b0, rxr0}, 32'h1);
    step(1);
    rxValid = 1'b0;
    chk("rx_blk_second", {31'b0, rxr0}, 32'h0);
    rd_at(32'h4, r0, r1);
    chk("rx_blk_second_data", r0, 32'h5A);
    wr_reg(32'h8, 32'h08, 4'h1);
    rd_at(32'h8, r0, r1);
    chk("rx_ovw_w1c", r1, 32'h0000_0005);
    rxValid = 1'b1; rx_data = 32'h77;
    wr_reg(32'h8, 32'h08, 4'h1);
    rxValid = 1'b0;
    rd_at(32'h8, r0, r1);
    chk("rx_ovw_event_wins", r1, 32'h0000_000D);
    addr_rc = 32'h4; rd_amba = 1'b1;
    step(1);
    rd_amba = 1'b0;

    // Scratch byte merge and decode
    wr_reg(32'h10, 32'hFFFF_FFFF, 4'hF);
    wr_reg(32'h10, 32'h1234_5678, 4'b0101);
    rd_at(32'h10, r0, r1);
    chk("scr_merge", r0, 32'hFF34_FF78);
    wr_reg(32'h10, 32'hDEAD_BEEF, 4'b0000);
    rd_at(32'h10, r0, r1);
    chk("scr_nostrb", r0, 32'hFF34_FF78);
    wr_reg(32'h14, 32'hCAFE_BABE, 4'hF);
    rd_at(32'h14, r0, r1);
    chk("scr1", r0, 32'hCAFE_BABE);
    wr_reg(32'h1C, 32'hFFFF_FFFF, 4'hF);
    rd_at(32'h1C, r0, r1);
    chk("unmapped", r0, 32'h0);
    rd_at(32'h18, r0, r1);
    chk("unmapped18", r0, 32'h0);
    rd_at(32'h1000_0010, r0, r1);
    chk("upper_ignored", r0, 32'hFF34_FF78);

    // Simultaneous RX pop and scratch write
    rxValid = 1'b1; rx_data = 32'h3C;
    step(1);
    rxValid = 1'b0;
    addr_rc = 32'h4; rd_amba = 1'b1;
    wr_reg(32'h14, 32'h0, 4'hF);
    rd_amba = 1'b0;
    rd_at(32'h14, r0, r1);
    chk("simul_wr", r0, 32'h0);
    rd_at(32'h8, r0, r1);
    chk("simul_rd", r0, 32'h0000_0004);

    // RX interrupt enable
    wr_reg(32'hC, 32'h5, 4'hF);
    rxValid = 1'b1; rx_data = 32'h81;
    step(1);
    rxValid = 1'b0;
    chk("irq_rx_lag", {31'b0, irq0}, 32'h0);
    step(1);
    chk("irq_rx", {31'b0, irq0}, 32'h1);

    // Asynchronous reset in the middle of traffic
    wr_reg(32'h0, 32'hAB, 4'hF);
    step(1);
    rst = 1'b0;
    #1;
    chk("async_txValid", {31'b0, txv0}, 32'h0);
    chk("async_irq", {31'b0, irq0}, 32'h0);
    chk("async_tx_data", txd1, 32'h0);
    step(2);
    rst = 1'b1;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
